direction_decoder: RTL

DIRECTION_DECODER -- requirements
Module: direction_decoder

---
 rtl/direction_decoder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/direction_decoder.sv
// PS/2 scan-code parser producing a one-hot direction level, step pulses with auto-repeat, and a held-key mask.
// Define ARROW_KEYS_EN to also map the extended arrow keys (E0 75/72/74/6B) onto the same direction bits.
module direction_decoder #(
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter int CNT_W        = 26
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [7:0]   rx_data,
   input  logic         rx_ready,
   output logic [3:0]   direction,
   output logic [3:0]   dir_pulse,
   output logic [3:0]   key_held,
   output logic         kb_error
);

   // state   | meaning
   // IDLE    | no prefix pending; next byte is a make, prefix or error byte
   // BRK     | F0 seen; next byte is a standard break code
   // EXT     | E0 seen; next byte is F0 or an extended make code
   // EXT_BRK | E0 F0 seen; next byte is an extended break code
   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [CNT_W-1:0] RATE_LD   = CNT_W'((REPEAT_RATE > 1) ? REPEAT_RATE - 1 : 0);
   localparam bit               REPEAT_EN = (REPEAT_DELAY > 0);

   state_t            state, state_nx;
   logic [3:0]        make_vec, brk_vec;
   logic              err;
   logic [3:0]        held_nx, dir_nx, pulse_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;

   function automatic logic [3:0] std_code(input logic [7:0] b);
      case (b)
         8'h1D:   return 4'b0001;
         8'h1B:   return 4'b0010;
         8'h23:   return 4'b0100;
         8'h1C:   return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

`ifdef ARROW_KEYS_EN
   function automatic logic [3:0] ext_code(input logic [7:0] b);
      case (b)
         8'h75:   return 4'b0001;
         8'h72:   return 4'b0010;
         8'h74:   return 4'b0100;
         8'h6B:   return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      make_vec = 4'b0000;
      brk_vec  = 4'b0000;
      err      = 1'b0;
      if (rx_ready) begin
         case (state)
            IDLE: begin
               if (rx_data == 8'hF0)                         state_nx = BRK;
               else if (rx_data == 8'hE0)                    state_nx = EXT;
               else if (rx_data == 8'h00 || rx_data == 8'hFF) err = 1'b1;
               else                                          make_vec = std_code(rx_data);
            end
            BRK: begin
               brk_vec  = std_code(rx_data);
               state_nx = IDLE;
            end
            EXT: begin
               if (rx_data == 8'hF0) state_nx = EXT_BRK;
               else begin
`ifdef ARROW_KEYS_EN
                  make_vec = ext_code(rx_data);
`endif
                  state_nx = IDLE;
               end
            end
            EXT_BRK: begin
`ifdef ARROW_KEYS_EN
               brk_vec  = ext_code(rx_data);
`endif
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // A make of an already-held key is typematic and leaves everything untouched.
   always_comb begin
      held_nx  = key_held;
      dir_nx   = direction;
      pulse_nx = 4'b0000;
      cnt_nx   = cnt;
      if (err) begin
         held_nx = 4'b0000;
         dir_nx  = 4'b0000;
      end else if (make_vec != 4'b0000 && (make_vec & key_held) == 4'b0000) begin
         held_nx = key_held | make_vec;
         dir_nx  = make_vec;
      end else if ((brk_vec & key_held) != 4'b0000) begin
         held_nx = key_held & ~brk_vec;
         if (direction == brk_vec) dir_nx = held_nx & (~held_nx + 4'd1);
      end

      // A direction change always restarts the timer, overriding a coincident expiry.
      if (dir_nx == 4'b0000) begin
         cnt_nx = '0;
      end else if (dir_nx != direction) begin
         cnt_nx   = DELAY_LD;
         pulse_nx = dir_nx;
      end else if (REPEAT_EN) begin
         if (cnt == '0) begin
            pulse_nx = direction;
            cnt_nx   = RATE_LD;
         end else begin
            cnt_nx = cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         key_held  <= 4'b0000;
         direction <= 4'b0000;
         dir_pulse <= 4'b0000;
         kb_error  <= 1'b0;
         cnt       <= '0;
      end else begin
         key_held  <= held_nx;
         direction <= dir_nx;
         dir_pulse <= pulse_nx;
         kb_error  <= err;
         cnt       <= cnt_nx;
      end
   end

endmodule
